alu_share_arbiter: RTL and testbench

- Time-shares one instance of the existing combinational ALU (A, B, alu_op -> C) between NUM_REQ requesters, e.g. per-core address-generation or coherence-side helpers in the multicore cache controller.
- Arbitrates round-robin, latches operands, registers the ALU result, and returns it with a valid/ready handshake to the granted requester only.
- One operation is in flight at a time.

---
 rtl/alu_share_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose: time-shares a single combinational ALU between NUM_REQ requesters.
// A round-robin arbiter picks one valid request while idle and latches its
// operands. The ALU result is then registered and returned to the granted
// requester with a valid/ready handshake. Only one operation is in flight at
// any time: IDLE -> EXEC -> RESP -> IDLE.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  per-requester operation request
//   req_a      operand A, slice i = [32*i+31:32*i]
//   req_b      operand B, slice i = [32*i+31:32*i]
//   req_op     ALU op code, slice i = [4*i+3:4*i]
//   req_ready  one-hot accept strobe (combinational, IDLE only)
//   rsp_valid  one-hot result valid (RESP only)
//   rsp_data   registered ALU result, shared by all requesters
//   rsp_err    set when the op code was above 10 (rsp_data is then 0)
//   rsp_ready  per-requester result accept; only the granted bit matters
//   busy       high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]  req_op,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Requester count at index width + 1, used for modulo wrap arithmetic.
  localparam logic [IDW:0] NREQ = NUM_REQ[IDW:0];

  logic [1:0]     state_reg, state_next;
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] grant_reg;
  logic [31:0]    a_reg, b_reg;
  logic [3:0]     op_reg;
  logic [31:0]    rsp_data_reg;
  logic           rsp_err_reg;

  logic [31:0]    a_arr  [NUM_REQ];
  logic [31:0]    b_arr  [NUM_REQ];
  logic [3:0]     op_arr [NUM_REQ];
  logic [IDW-1:0] cand   [NUM_REQ];

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] gidx;
  logic [IDW:0]   gidx_inc;
  logic [IDW-1:0] rr_wrap;
  logic [31:0]    alu_c;

  // -------------------------------------------------------------------------
  // Per-requester operand unpacking and the rotated scan order.
  // cand[k] is the k-th requester examined, starting from rr_ptr.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      localparam int             OFS_I = gi;
      localparam logic [IDW:0]   OFS   = OFS_I[IDW:0];
      logic [IDW:0] sum;
      logic [IDW:0] wrap;

      assign a_arr[gi]  = req_a[32*gi +: 32];
      assign b_arr[gi]  = req_b[32*gi +: 32];
      assign op_arr[gi] = req_op[4*gi +: 4];

      assign sum      = {1'b0, rr_ptr_reg} + OFS;
      assign wrap     = sum - NREQ;
      assign cand[gi] = (sum >= NREQ) ? wrap[IDW-1:0] : sum[IDW-1:0];

      // Reset forces the accept strobe low even while req_valid is held.
      assign req_ready[gi] = !reset && (state_reg == IDLE) && win_found &&
                             (win_idx == OFS[IDW-1:0]);
      assign rsp_valid[gi] = (state_reg == RESP) && (gidx == OFS[IDW-1:0]);
    end
  endgenerate

  // Walk the scan order from lowest to highest priority so the last hit,
  // i.e. the one closest to rr_ptr, wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand[k]]) begin
        win_found = 1'b1;
        win_idx   = cand[k];
      end
    end
  end

  // Out-of-range grant values (only possible for non-power-of-2 NUM_REQ)
  // fall back to requester 0.
  assign gidx     = ({1'b0, grant_reg} < NREQ) ? grant_reg : '0;
  assign gidx_inc = {1'b0, gidx} + {{IDW{1'b0}}, 1'b1};
  assign rr_wrap  = (gidx_inc == NREQ) ? '0 : gidx_inc[IDW-1:0];

  // -------------------------------------------------------------------------
  // Shared ALU. Shift amounts use B[4:0]; results wrap at 32 bits.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] alu(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [3:0]  op);
    case (op)
      4'd0:    alu = a + b;
      4'd1:    alu = a << b[4:0];
      4'd2,
      4'd3:    alu = {31'd0, (a < b)};
      4'd4:    alu = a ^ b;
      4'd5:    alu = a >> b[4:0];
      4'd6:    alu = $signed(a) >>> b[4:0];
      4'd7:    alu = a | b;
      4'd8:    alu = a & b;
      4'd9:    alu = a - b;
      4'd10:   alu = b;
      default: alu = 32'd0;
    endcase
  endfunction

  assign alu_c = alu(a_reg, b_reg, op_reg);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready[gidx]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          // Operands are sampled only on the accept edge.
          if (win_found) begin
            a_reg     <= a_arr[win_idx];
            b_reg     <= b_arr[win_idx];
            op_reg    <= op_arr[win_idx];
            grant_reg <= win_idx;
          end
        end
        EXEC: begin
          rsp_data_reg <= alu_c;
          rsp_err_reg  <= (op_reg > 4'd10);
        end
        RESP: begin
          if (rsp_ready[gidx]) rr_ptr_reg <= rr_wrap;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = rsp_data_reg;
  assign rsp_err  = rsp_err_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
module tb_alu_share_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*4-1:0]  req_op;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic [N-1:0]    rsp_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int exp_rr = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  // Reference ALU from the op table.
  function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  op);
    int sh;
    sh = int'(b % 32);
    case (int'(op))
      0:       return a + b;
      1:       return a << sh;
      2, 3:    return (a < b) ? 32'd1 : 32'd0;
      4:       return a ^ b;
      5:       return a >> sh;
      6:       return $signed(a) >>> sh;
      7:       return a | b;
      8:       return a & b;
      9:       return a - b;
      10:      return b;
      default: return 32'd0;
    endcase
  endfunction

  // Round-robin winner: first valid index scanning from rr modulo N, or -1.
  function automatic int ref_winner(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = '1;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h err=%b busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, busy);
    end
    reset     = 1'b0;
    req_valid = '0;
    exp_rr    = 0;
  endtask

  task automatic test_single;
    logic [31:0] exp;
    @(negedge clk);
    req_valid    = 2'b01;
    req_a[31:0]  = 32'd5;
    req_b[31:0]  = 32'd7;
    req_op[3:0]  = 4'd0;
    rsp_ready    = '1;
    exp          = ref_alu(32'd5, 32'd7, 4'd0);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_accept: req_ready=%b expected 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL single_exec: busy=%b rsp_valid=%b req_ready=%b expected 1/00/00",
               busy, rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== exp || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: vld=%b data=%h err=%b expected 01/%h/0",
               rsp_valid, rsp_data, rsp_err, exp);
    end
    $display("txn single: req=0 a=5 b=7 op=0 data=%h", rsp_data);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: busy=%b rsp_valid=%b expected 0/00", busy, rsp_valid);
    end
    exp_rr = 1 % N;
  endtask

  task automatic test_contention;
    int win;
    int cnt0, cnt1;
    logic [N-1:0] oh;
    logic [31:0] exp;
    cnt0 = 0;
    cnt1 = 0;
    @(negedge clk);
    req_valid     = '1;
    req_a[31:0]   = 32'd1;
    req_b[31:0]   = 32'd3;
    req_op[3:0]   = 4'd1;
    req_a[63:32]  = 32'hFFFF_FFFF;
    req_b[63:32]  = 32'd1;
    req_op[7:4]   = 4'd0;
    rsp_ready     = '1;
    for (int t = 0; t < 4; t++) begin
      #1;
      win = ref_winner(req_valid, exp_rr);
      oh = '0;
      oh[win] = 1'b1;
      exp = ref_alu(req_a[32*win +: 32], req_b[32*win +: 32], req_op[4*win +: 4]);
      checks++;
      if (req_ready !== oh) begin
        errors++;
        $display("FAIL contention_grant%0d: req_ready=%b expected %b", t, req_ready, oh);
      end
      if (req_ready == 2'b01) cnt0++;
      else if (req_ready == 2'b10) cnt1++;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== oh || rsp_data !== exp) begin
        errors++;
        $display("FAIL contention_resp%0d: vld=%b data=%h expected %b/%h",
                 t, rsp_valid, rsp_data, oh, exp);
      end
      $display("txn contention: req=%0d data=%h", win, rsp_data);
      exp_rr = (win + 1) % N;
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (cnt0 != 2 || cnt1 != 2) begin
      errors++;
      $display("FAIL contention_fairness: grants r0=%0d r1=%0d expected 2/2", cnt0, cnt1);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp;
    @(negedge clk);
    req_valid    = 2'b10;
    req_a[63:32] = 32'd3;
    req_b[63:32] = 32'd5;
    req_op[7:4]  = 4'd9;
    rsp_ready    = '0;
    exp          = ref_alu(32'd3, 32'd5, 4'd9);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_accept: req_ready=%b expected 10", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_exec_ignore: req_ready=%b busy=%b expected 00/1", req_ready, busy);
    end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== exp || busy !== 1'b1 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b data=%h busy=%b rdy=%b expected 10/%h/1/00",
                 c, rsp_valid, rsp_data, busy, req_ready, exp);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b expected 10", rsp_valid);
    end
    $display("txn backpressure: req=1 a=3 b=5 op=9 data=%h", rsp_data);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL bp_done: busy=%b rsp_valid=%b expected 0/00", busy, rsp_valid);
    end
    exp_rr = 0;
  endtask

  task automatic test_illegal_op;
    logic [3:0]  ops [2];
    logic [31:0] as  [2];
    logic [31:0] bs  [2];
    logic [31:0] exp;
    logic        eerr;
    ops[0] = 4'd12; as[0] = 32'd1; bs[0] = 32'd1;
    ops[1] = 4'd10; as[1] = 32'd0; bs[1] = 32'hA5;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      req_valid   = 2'b01;
      req_a[31:0] = as[t];
      req_b[31:0] = bs[t];
      req_op[3:0] = ops[t];
      rsp_ready   = '1;
      exp  = ref_alu(as[t], bs[t], ops[t]);
      eerr = (ops[t] > 4'd10);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== exp || rsp_err !== eerr) begin
        errors++;
        $display("FAIL illegal_op%0d: vld=%b data=%h err=%b expected 01/%h/%b",
                 t, rsp_valid, rsp_data, rsp_err, exp, eerr);
      end
      $display("txn illegal_op: op=%0d data=%h err=%b", ops[t], rsp_data, rsp_err);
      @(negedge clk);
      exp_rr = 1;
    end
  endtask

  task automatic test_wrong_ready;
    @(negedge clk);
    req_valid   = 2'b01;
    req_a[31:0] = 32'h1234_0000;
    req_b[31:0] = 32'h0000_5678;
    req_op[3:0] = 4'd0;
    rsp_ready   = 2'b10;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 2'b01 || busy !== 1'b1) begin
        errors++;
        $display("FAIL wrong_ready%0d: rsp_valid=%b busy=%b expected 01/1", c, rsp_valid, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wrong_ready_done: busy=%b data=%h expected 0/12345678", busy, rsp_data);
    end
    $display("txn wrong_ready: req=0 data=%h", rsp_data);
    exp_rr = 1;
  endtask

  task automatic test_reset_midop;
    logic [31:0] exp;
    @(negedge clk);
    req_valid   = 2'b01;
    req_a[31:0] = 32'd9;
    req_b[31:0] = 32'd4;
    req_op[3:0] = 4'd0;
    rsp_ready   = '1;
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_exec: busy=%b expected 1", busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b vld=%b data=%h err=%b busy=%b expected all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, busy);
    end
    @(negedge clk);
    reset  = 1'b0;
    exp_rr = 0;
    req_valid    = 2'b11;
    req_a[63:32] = 32'hF0;
    req_b[63:32] = 32'h0F;
    req_op[7:4]  = 4'd7;
    exp = ref_alu(32'hF0, 32'h0F, 4'd7);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL midreset_rrptr: req_ready=%b expected 01", req_ready);
    end
    #1;
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL midreset_accept1: req_ready=%b expected 10", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== exp || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_resp: vld=%b data=%h err=%b expected 10/%h/0",
               rsp_valid, rsp_data, rsp_err, exp);
    end
    $display("txn after_reset: req=1 data=%h", rsp_data);
    @(negedge clk);
    exp_rr = 0;
  endtask

  task automatic test_random;
    logic [N-1:0] v, oh;
    logic [31:0]  ea, eb, exp;
    logic [3:0]   eo;
    int           r, win, d;
    for (int t = 0; t < 40; t++) begin
      r = $urandom;
      v = r[N-1:0];
      req_valid = v;
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
        r = $urandom;
        req_op[4*i +: 4] = r[3:0];
      end
      rsp_ready = '0;
      #1;
      win = ref_winner(v, exp_rr);
      oh = '0;
      if (win >= 0) oh[win] = 1'b1;
      checks++;
      if (req_ready !== oh) begin
        errors++;
        $display("FAIL rand%0d_grant: req_ready=%b expected %b", t, req_ready, oh);
      end
      if (win < 0) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL rand%0d_idle: busy=%b expected 0", t, busy);
        end
        continue;
      end
      ea  = req_a[32*win +: 32];
      eb  = req_b[32*win +: 32];
      eo  = req_op[4*win +: 4];
      exp = ref_alu(ea, eb, eo);
      @(negedge clk);
      // Operands change after acceptance and must not affect the result.
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
      end
      r = $urandom;
      req_valid = r[N-1:0];
      #1;
      checks++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_exec: req_ready=%b busy=%b expected 0/1", t, req_ready, busy);
      end
      @(negedge clk);
      d = $urandom_range(0, 2);
      rsp_ready = ~oh;
      for (int c = 0; c < d; c++) begin
        #1;
        checks++;
        if (rsp_valid !== oh || rsp_data !== exp) begin
          errors++;
          $display("FAIL rand%0d_hold: vld=%b data=%h expected %b/%h",
                   t, rsp_valid, rsp_data, oh, exp);
        end
        @(negedge clk);
      end
      rsp_ready = oh;
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== oh || rsp_data !== exp || rsp_err !== (eo > 4'd10)) begin
        errors++;
        $display("FAIL rand%0d_resp: vld=%b data=%h err=%b expected %b/%h/%b",
                 t, rsp_valid, rsp_data, rsp_err, oh, exp, (eo > 4'd10));
      end
      $display("txn rand%0d: req=%0d a=%h b=%h op=%0d data=%h err=%b",
               t, win, ea, eb, eo, rsp_data, rsp_err);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_done: busy=%b expected 0", t, busy);
      end
      exp_rr = (win + 1) % N;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal_op();
    test_wrong_ready();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
